// File: rtl/lut_layer_if.sv
// Handshake and configuration bundle for the time-multiplexed LUT layer.
// master drives vectors/config into the block; slave is the sequencer side.
interface lut_layer_if #(
  parameter int IN_BITS     = 64,
  parameter int NUM_NEURONS = 16,
  parameter int OUT_W       = 2,
  parameter int IDX_W       = $clog2(IN_BITS),
  parameter int NID_W       = $clog2(NUM_NEURONS),
  parameter int CFG_W       = (OUT_W > IDX_W) ? OUT_W : IDX_W
);
  logic                         in_valid;
  logic                         in_ready;
  logic [IN_BITS-1:0]           in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_NEURONS*OUT_W-1:0] out_data;
  logic                         cfg_we;
  logic                         cfg_sel;
  logic [NID_W-1:0]             cfg_neuron;
  logic [6:0]                   cfg_addr;
  logic [CFG_W-1:0]             cfg_data;
  logic                         cfg_err;
  logic                         busy;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_neuron, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_err, busy
  );
  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_neuron, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_err, busy
  );
endinterface

// File: rtl/lut_layer_sequencer.sv
// Evaluates NUM_NEURONS 7-input LUT neurons one per cycle against a latched
// input vector, using a shared truth-table RAM and a per-neuron wiring table.
module lut_layer_sequencer #(
  parameter int IN_BITS     = 64,
  parameter int NUM_NEURONS = 16,
  parameter int FANIN       = 7,
  parameter int OUT_W       = 2,
  parameter int IDX_W       = $clog2(IN_BITS),
  parameter int NID_W       = $clog2(NUM_NEURONS)
) (
  input logic       clk,
  input logic       rst,
  lut_layer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state;
  logic [IN_BITS-1:0]           in_reg;
  logic [NID_W-1:0]             cnt;
  logic [NID_W-1:0]             nid_q;
  logic                         rd_vld;
  logic [OUT_W-1:0]             rd_data;
  logic [NUM_NEURONS*OUT_W-1:0] out_q;
  logic                         err_q;
  logic [FANIN-1:0]             addr;
  logic                         cfg_ok, wr_tt, wr_conn;

  // Tables are deliberately left unreset; software loads them before use.
  logic [OUT_W-1:0] ram  [2**(NID_W+FANIN)];
  logic [IDX_W-1:0] conn [NUM_NEURONS][FANIN];

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = out_q;
  assign bus.cfg_err   = err_q;

  always_comb begin
    addr = '0;
    for (int k = 0; k < FANIN; k++) addr[k] = in_reg[conn[cnt][k]];
  end

  always_comb begin
    cfg_ok = (32'(bus.cfg_neuron) < NUM_NEURONS);
    if (bus.cfg_sel)
      cfg_ok = cfg_ok && (32'(bus.cfg_addr) < FANIN) && (32'(bus.cfg_data) < IN_BITS);
  end

  assign wr_tt   = bus.cfg_we && (state == IDLE) && cfg_ok && !bus.cfg_sel;
  assign wr_conn = bus.cfg_we && (state == IDLE) && cfg_ok &&  bus.cfg_sel;

  always_ff @(posedge clk) begin
    if (wr_tt)   ram[{bus.cfg_neuron, bus.cfg_addr}] <= bus.cfg_data[OUT_W-1:0];
    if (wr_conn) conn[bus.cfg_neuron][bus.cfg_addr[2:0]] <= bus.cfg_data[IDX_W-1:0];
    rd_data <= ram[{cnt, addr}];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      in_reg <= '0;
      cnt    <= '0;
      nid_q  <= '0;
      rd_vld <= 1'b0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      rd_vld <= 1'b0;
      err_q  <= bus.cfg_we && !(wr_tt || wr_conn);
      // Result lands one cycle after issue, tagged by the delayed neuron index.
      if (rd_vld) out_q[nid_q*OUT_W +: OUT_W] <= rd_data;
      case (state)
        IDLE: if (bus.in_valid) begin
          in_reg <= bus.in_data;
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: begin
          rd_vld <= 1'b1;
          nid_q  <= cnt;
          if (32'(cnt) == NUM_NEURONS - 1) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: state <= DONE;
        DONE:  if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
